// File: rtl/aes_spi_responder.sv
// Bit-serial slave front-end for an external AES core: collects a 256-bit block+key
// frame MSB-first, runs the core through a start/done handshake, shifts the result back.
module aes_spi_responder #(
    parameter int BLK_W   = 128,
    parameter int KEY_W   = 128,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cs,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_valid,
    output logic             core_start,
    output logic [BLK_W-1:0] core_block,
    output logic [KEY_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_result,
    input  logic             core_done,
    output logic             busy,
    output logic             err,
    output logic [2:0]       dbg_state
);
    localparam int FW = BLK_W + KEY_W;
    localparam int CW = $clog2(FW + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int OW = $clog2(BLK_W);
    localparam logic [CW-1:0] IN_LAST  = CW'(FW - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
    localparam logic [OW-1:0] OUT_LAST = OW'(BLK_W - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SHIFT_IN  = 3'd1,
        START     = 3'd2,
        WAIT      = 3'd3,
        SHIFT_OUT = 3'd4,
        HOLD      = 3'd5
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   count;
    logic [FW-2:0]   sr;
    logic [FW-1:0]   frame;
    logic [BLK_W-2:0] osr;
    logic [OW-1:0]   ocnt;
    logic [TW-1:0]   tcnt;
    logic            abort;

    // The newest serial bit completes the frame in the same cycle it is sampled.
    assign frame = {sr, mosi};
    assign abort = (state != IDLE) && cs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Core handshake: core_start is a one-cycle pulse while in START; core_done is a
    // single-cycle strobe honoured only in WAIT, where core_result is captured with it.
    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      if (!cs) next_state = SHIFT_IN;
                SHIFT_IN:  if (count == IN_LAST) next_state = START;
                START:     next_state = WAIT;
                WAIT: begin
                    if (core_done) next_state = SHIFT_OUT;
                    else if (tcnt == T_LAST) next_state = HOLD;
                end
                SHIFT_OUT: if (ocnt == OUT_LAST) next_state = HOLD;
                HOLD:      next_state = HOLD;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        core_start = (state == START);
        busy       = (state != IDLE);
        dbg_state  = state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count      <= '0;
            sr         <= '0;
            osr        <= '0;
            ocnt       <= '0;
            tcnt       <= '0;
            core_block <= '0;
            core_key   <= '0;
            miso       <= 1'b0;
            miso_valid <= 1'b0;
            err        <= 1'b0;
        end else if (abort) begin
            // Latched block/key and err survive an abort.
            count      <= '0;
            miso       <= 1'b0;
            miso_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!cs) begin
                        sr    <= frame[FW-2:0];
                        count <= CW'(1);
                        err   <= 1'b0;
                    end
                end
                SHIFT_IN: begin
                    sr    <= frame[FW-2:0];
                    count <= count + 1'b1;
                    if (count == IN_LAST) begin
                        core_block <= frame[FW-1:KEY_W];
                        core_key   <= frame[KEY_W-1:0];
                    end
                end
                START: begin
                    tcnt <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        miso       <= core_result[BLK_W-1];
                        miso_valid <= 1'b1;
                        osr        <= core_result[BLK_W-2:0];
                        ocnt       <= '0;
                    end else if (tcnt == T_LAST) begin
                        err <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                SHIFT_OUT: begin
                    if (ocnt == OUT_LAST) begin
                        miso       <= 1'b0;
                        miso_valid <= 1'b0;
                    end else begin
                        miso <= osr[BLK_W-2];
                        osr  <= osr << 1;
                        ocnt <= ocnt + 1'b1;
                    end
                end
                default: begin
                    miso       <= 1'b0;
                    miso_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_aes_spi_responder.sv
// Directed bench for aes_spi_responder: a default-timeout instance for the data path and
// a TIMEOUT=15 instance for the timeout and done-vs-timeout race.
module tb_aes_spi_responder;
    logic         clk = 1'b0;
    logic         rst;
    logic         cs;
    logic         mosi;
    logic [127:0] core_result;
    logic         core_done;
    logic         core_done_t;

    logic         miso, miso_valid, core_start, busy, err;
    logic [127:0] core_block, core_key;
    logic [2:0]   dbg_state;
    logic         miso_t, miso_valid_t, core_start_t, busy_t, err_t;
    logic [127:0] core_block_t, core_key_t;
    logic [2:0]   dbg_state_t;

    int pass_cnt = 0;
    int total_cnt = 0;
    int start_cnt = 0;
    int valid_cnt = 0;
    int valid_t_cnt = 0;

    typedef struct {
        logic [127:0] block;
        logic [127:0] key;
        logic [127:0] result;
        int           lat;
        logic [127:0] exp_ser;
    } vec_t;

    vec_t vecs[3];

    aes_spi_responder dut (
        .clk(clk), .rst(rst), .cs(cs), .mosi(mosi),
        .miso(miso), .miso_valid(miso_valid), .core_start(core_start),
        .core_block(core_block), .core_key(core_key),
        .core_result(core_result), .core_done(core_done),
        .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    aes_spi_responder #(.TIMEOUT(15)) dut_t (
        .clk(clk), .rst(rst), .cs(cs), .mosi(mosi),
        .miso(miso_t), .miso_valid(miso_valid_t), .core_start(core_start_t),
        .core_block(core_block_t), .core_key(core_key_t),
        .core_result(core_result), .core_done(core_done_t),
        .busy(busy_t), .err(err_t), .dbg_state(dbg_state_t)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (core_start) start_cnt++;
        if (miso_valid) valid_cnt++;
        if (miso_valid_t) valid_t_cnt++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic send_frame(input logic [127:0] blk, input logic [127:0] key, input int nbits);
        logic [255:0] f;
        f = {blk, key};
        for (int i = 0; i < nbits; i++) begin
            cs   = 1'b0;
            mosi = f[255-i];
            @(negedge clk);
        end
    endtask

    // Model core: done is sampled lat posedges after the one that saw core_start.
    task automatic core_reply(input logic [127:0] result, input int lat);
        repeat (lat) @(negedge clk);
        core_result = result;
        core_done   = 1'b1;
        @(negedge clk);
        core_done   = 1'b0;
    endtask

    task automatic collect(input bit use_t, input int n, output logic [127:0] got, output int nv);
        got = '0;
        nv  = 0;
        for (int i = 0; i < n; i++) begin
            if (use_t ? miso_valid_t : miso_valid) nv++;
            got = {got[126:0], (use_t ? miso_t : miso)};
            @(negedge clk);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int s0, v0, nv;
        logic [127:0] got;
        s0 = start_cnt;
        v0 = valid_cnt;
        send_frame(v.block, v.key, 256);
        check("start_latency", core_start, 1);
        check("core_block", core_block, v.block);
        check("core_key", core_key, v.key);
        core_reply(v.result, v.lat);
        collect(1'b0, 128, got, nv);
        check("serial_result", got, v.exp_ser);
        check("valid_bits", nv, 128);
        check("valid_dropped", {miso_valid, miso}, 0);
        check("busy_before_cs", busy, 1);
        cs = 1'b1;
        @(negedge clk);
        check("busy_after_cs", busy, 0);
        check("start_pulses", start_cnt - s0, 1);
        check("valid_cycles", valid_cnt - v0, 128);
    endtask

    initial begin
        int nv;
        int s0;
        int vt0;
        logic [127:0] got;
        logic [127:0] r;

        vecs[0] = '{block: 128'h00112233445566778899aabbccddeeff, key: 128'h000102030405060708090a0b0c0d0e0f,
                    result: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, lat: 20,
                    exp_ser: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{block: 128'h69c4e0d86a7b0430d8cdb78070b4c55a, key: 128'h000102030405060708090a0b0c0d0e0f,
                    result: 128'h00112233445566778899aabbccddeeff, lat: 20,
                    exp_ser: 128'h00112233445566778899aabbccddeeff};
        vecs[2] = '{block: 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f, key: 128'hffffffffffffffffffffffffffffffff,
                    result: 128'h80000000000000000000000000000001, lat: 1,
                    exp_ser: 128'h80000000000000000000000000000001};

        cs = 1'b1;
        mosi = 1'b0;
        core_done = 1'b0;
        core_done_t = 1'b0;
        core_result = '0;
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl", {miso, miso_valid, core_start, busy, err, dbg_state}, 0);
        check("reset_ctrl_t", {miso_t, miso_valid_t, core_start_t, busy_t, err_t, dbg_state_t}, 0);
        check("reset_data", core_block | core_key | core_block_t | core_key_t, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 3; i++) run_vector(vecs[i]);

        // Mid-frame abort after 100 bits, then a clean frame.
        s0 = start_cnt;
        send_frame(vecs[0].block, vecs[0].key, 100);
        cs = 1'b1;
        @(negedge clk);
        check("abort_idle", busy, 0);
        repeat (30) @(negedge clk);
        check("abort_no_start", start_cnt - s0, 0);
        check("abort_keeps_block", core_block, vecs[2].block);
        run_vector(vecs[0]);

        // Timeout on the TIMEOUT=15 instance.
        vt0 = valid_t_cnt;
        send_frame(vecs[0].block, vecs[0].key, 256);
        check("start_t", core_start_t, 1);
        repeat (15) @(negedge clk);
        check("err_before_timeout", err_t, 0);
        @(negedge clk);
        check("err_at_timeout", err_t, 1);
        check("hold_after_timeout", dbg_state_t, 3'd5);
        check("no_valid_on_timeout", valid_t_cnt - vt0, 0);
        cs = 1'b1;
        @(negedge clk);
        check("err_sticky", {err_t, busy_t}, 2'b10);
        cs = 1'b0;
        @(negedge clk);
        check("err_cleared_new_frame", {err_t, busy_t}, 2'b01);
        cs = 1'b1;
        @(negedge clk);

        // core_done lands on the same posedge the timeout would expire.
        send_frame(vecs[1].block, vecs[1].key, 256);
        repeat (15) @(negedge clk);
        core_result = vecs[1].result;
        core_done_t = 1'b1;
        @(negedge clk);
        core_done_t = 1'b0;
        collect(1'b1, 128, got, nv);
        check("race_result", got, vecs[1].result);
        check("race_valid_bits", nv, 128);
        check("race_err", err_t, 0);
        cs = 1'b1;
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        @(negedge clk);
        check("done_after_abort", {miso_valid, busy}, 0);

        // Asynchronous reset in the middle of SHIFT_OUT.
        send_frame(vecs[0].block, vecs[0].key, 256);
        core_reply(vecs[0].result, 5);
        collect(1'b0, 60, got, nv);
        r = vecs[0].result;
        check("partial_bits", got[59:0], r[127:68]);
        check("pre_reset_valid", miso_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_ctrl", {miso, miso_valid, core_start, busy, err, dbg_state}, 0);
        check("async_reset_data", core_block | core_key, 0);
        @(negedge clk);
        rst = 1'b1;
        cs = 1'b1;
        @(negedge clk);
        run_vector(vecs[0]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/aes_spi_responder.md
Name: aes_spi_responder

Overview:
- Serial slave front-end for the AES engines; the far end of the bit-serial CS/MOSI/MISO link that the top-level test wrapper drives.
- Receives one 256-bit frame (128-bit block, then 128-bit key) MSB-first and hands it to an attached AES core via a start/done handshake.
- Shifts the 128-bit core result back MSB-first with an explicit valid qualifier, replacing X-detection on MISO.
- The core is external, so the same block serves both the encrypt and decrypt slaves.

Parameters:
- BLK_W, 128, block and result width in bits.
- KEY_W, 128, key width in bits.
- TIMEOUT, 1023, maximum cycles to wait for core_done before reporting an error; width is ceil(log2(TIMEOUT+1)).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active-low; high aborts any frame.
- mosi  in  1  serial input bit, sampled on posedge while cs low.
- miso  out  1  serial result bit, registered.
- miso_valid  out  1  high only while miso carries a result bit.
- core_start  out  1  one-cycle start pulse to the AES core.
- core_block  out  BLK_W  received block, MSB = first bit received.
- core_key  out  KEY_W  received key, MSB = first key bit received.
- core_result  in  BLK_W  core output, sampled when core_done is high.
- core_done  in  1  core completion strobe.
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky timeout flag; cleared at the next frame start.

Behaviour:
- Reset (rst low, asynchronous) clears everything: state IDLE, bit counter 0, shift registers 0, miso 0, miso_valid 0, core_start 0, busy 0, err 0.
- IDLE: when cs is low at a posedge, sample mosi as bit 0, clear err, set count=1, go to SHIFT_IN.
- SHIFT_IN:
  - While cs is low, shift mosi into a 256-bit register on each posedge and increment count.
  - On the posedge that samples bit 255, latch core_block = bits 0..127 and core_key = bits 128..255, then go to START.
- START: core_start is high for exactly this one cycle; the TIMEOUT counter is cleared; go to WAIT.
- WAIT:
  - On the posedge where core_done=1, load core_result into the output shift register and go to SHIFT_OUT.
  - The timeout counter increments every cycle in WAIT. When it reaches TIMEOUT, set err=1 and go to HOLD.
  - A core_done and the timeout landing on the same posedge: core_done wins.
- SHIFT_OUT:
  - miso = current MSB of the output register and miso_valid=1, both registered.
  - The first bit appears in the cycle after the one in which core_done was sampled.
  - Shift left once per posedge, for exactly 128 cycles.
  - After bit 127, drop miso_valid, force miso=0, go to HOLD.
- HOLD: miso=0 and miso_valid=0; stay until cs is seen high, then go to IDLE.
- Abort: cs high in any non-IDLE state goes to IDLE on the next posedge.
  - Clear miso_valid, miso and count.
  - core_block and core_key keep their last values.
  - A core_done arriving after an abort is ignored.
- Back-to-back frames: cs must be high for at least one posedge between frames. A frame whose cs never rises after HOLD is never restarted.
- Counters: the bit counter is 9 bits, 0..256, and must not wrap inside a frame. A result never starts shifting before all 256 input bits are received.
- Latency: the last input bit at posedge N gives core_start high in cycle N+1. For a core with done latency L, the first miso bit is valid in cycle N+L+2.

Test Plan:
- FIPS-197 encrypt:
  - Stimulus: with cs low, shift block 00112233445566778899aabbccddeeff then key 000102030405060708090a0b0c0d0e0f into a model core that returns 69c4e0d86a7b0430d8cdb78070b4c55a after 20 cycles.
  - Required: core_block and core_key match the inputs, core_start pulses exactly once, miso_valid is high for exactly 128 cycles, and the collected bits equal 69c4e0d8...c55a.
- Decrypt path:
  - Stimulus: frame 69c4e0d86a7b0430d8cdb78070b4c55a plus the same key, with the core returning 00112233445566778899aabbccddeeff.
  - Required: the serial result equals 00112233...eeff and busy falls only after cs rises.
- Mid-frame abort:
  - Stimulus: raise cs after 100 input bits, then send a full valid frame.
  - Required: no core_start during the aborted frame; the second frame completes correctly.
- Timeout:
  - Stimulus: TIMEOUT=15 and core_done held low.
  - Required: err=1 fifteen cycles after core_start, miso_valid stays 0, then err=0 after cs cycles high→low for the next frame.
- Async reset:
  - Stimulus: assert rst low while in SHIFT_OUT at bit 60.
  - Required: all outputs are 0 immediately without waiting for a clock edge, and a following frame works normally.
- Simultaneous events:
  - Stimulus: core_done arrives in the same cycle the timeout expires.
  - Required: the result is shifted out and err stays 0.
